alu_sequencer: RTL and testbench

Controller that sequences the shared 32-bit ALU and its flag unit for single-word and two-pass 64-bit arithmetic. It accepts operation requests over a valid/ready handshake and drives the ALU operands, control and carry-in. It captures the result and the Z/O/C/N flags, holds the architectural status register, and returns results over a valid/ready response channel. It sits between instruction decode and the ALU/flag datapath.

---
 rtl/alu_sequencer_if.sv | 29 ++
 rtl/alu_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request/response channel between instruction decode and the ALU sequencer.
interface alu_sequencer_if;
  localparam int unsigned DataW = 32;
  localparam int unsigned OpW   = 3;

  logic             reqValid;
  logic             reqReady;
  logic [OpW-1:0]   reqOp;
  logic             reqSetFlags;
  logic [DataW-1:0] reqA;
  logic [DataW-1:0] reqB;
  logic [DataW-1:0] reqAHi;
  logic [DataW-1:0] reqBHi;
  logic             rspValid;
  logic             rspReady;
  logic [DataW-1:0] rspResult;
  logic [DataW-1:0] rspResultHi;
  logic             rspErr;

  modport master (
    output reqValid, reqOp, reqSetFlags, reqA, reqB, reqAHi, reqBHi, rspReady,
    input  reqReady, rspValid, rspResult, rspResultHi, rspErr
  );

  modport slave (
    input  reqValid, reqOp, reqSetFlags, reqA, reqB, reqAHi, reqBHi, rspReady,
    output reqReady, rspValid, rspResult, rspResultHi, rspErr
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences the shared 32-bit ALU for single-word and two-pass 64-bit ops,
// captures results/flags and owns the architectural status register.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  alu_sequencer_if.slave bus,
  output logic [31:0] aluA,
  output logic [31:0] aluB,
  output logic [1:0]  aluCtrl,
  output logic        aluCin,
  input  logic [31:0] aluBusOut,
  input  logic        aluCarryOut,
  input  logic        flagZ,
  input  logic        flagO,
  input  logic        flagC,
  input  logic        flagN,
  output logic        statusZ,
  output logic        statusO,
  output logic        statusC,
  output logic        statusN
);
  localparam int unsigned DataW = 32;
  localparam int unsigned OpW   = 3;

  localparam logic [OpW-1:0] OpAdd   = 3'b000;
  localparam logic [OpW-1:0] OpSub   = 3'b001;
  localparam logic [OpW-1:0] OpAdc   = 3'b010;
  localparam logic [OpW-1:0] OpCmp   = 3'b011;
  localparam logic [OpW-1:0] OpAdd64 = 3'b100;
  localparam logic [OpW-1:0] OpSub64 = 3'b101;

  typedef enum logic [2:0] {IDLE, EXEC, LO, HI, RESP} state_t;

  state_t           state, nextState;
  logic             accept, isSub, updFlags;
  logic [OpW-1:0]   opNext, opReg;
  logic             setFlagsReg, loZ;
  logic [DataW-1:0] aHiReg, bHiReg;
  logic [DataW-1:0] aluANext, aluBNext;
  logic [1:0]       aluCtrlNext;
  logic             aluCinNext;

  assign bus.reqReady = (state == IDLE) && !reset;
  assign accept       = bus.reqValid && bus.reqReady;
  assign updFlags     = setFlagsReg || (opReg == OpCmp);

  // Next state plus the ALU drive for the pass that the next state performs.
  always_comb begin
    nextState   = state;
    aluANext    = '0;
    aluBNext    = '0;
    aluCtrlNext = 2'b00;
    aluCinNext  = 1'b0;
    opNext      = (state == IDLE) ? bus.reqOp : opReg;
    isSub       = (opNext == OpSub) || (opNext == OpCmp) || (opNext == OpSub64);

    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.reqOp)
            OpAdd, OpSub, OpAdc, OpCmp: nextState = EXEC;
            OpAdd64, OpSub64:           nextState = LO;
            default:                    nextState = RESP;
          endcase
        end
      end
      EXEC:    nextState = RESP;
      LO:      nextState = HI;
      HI:      nextState = RESP;
      RESP:    if (bus.rspReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase

    case (nextState)
      EXEC: begin
        aluANext    = bus.reqA;
        aluBNext    = bus.reqB;
        aluCtrlNext = {1'b0, isSub};
        aluCinNext  = (opNext == OpAdc) ? statusC : isSub;
      end
      LO: begin
        aluANext    = bus.reqA;
        aluBNext    = bus.reqB;
        aluCtrlNext = {1'b0, isSub};
        aluCinNext  = isSub;
      end
      HI: begin
        // carry-in of the high pass is the low-pass carry-out (loC)
        aluANext    = aHiReg;
        aluBNext    = bHiReg;
        aluCtrlNext = {1'b0, isSub};
        aluCinNext  = aluCarryOut;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      aluA            <= '0;
      aluB            <= '0;
      aluCtrl         <= 2'b00;
      aluCin          <= 1'b0;
      opReg           <= '0;
      setFlagsReg     <= 1'b0;
      aHiReg          <= '0;
      bHiReg          <= '0;
      loZ             <= 1'b0;
      bus.rspValid    <= 1'b0;
      bus.rspErr      <= 1'b0;
      bus.rspResult   <= '0;
      bus.rspResultHi <= '0;
      statusZ         <= 1'b0;
      statusO         <= 1'b0;
      statusC         <= 1'b0;
      statusN         <= 1'b0;
    end else begin
      state        <= nextState;
      aluA         <= aluANext;
      aluB         <= aluBNext;
      aluCtrl      <= aluCtrlNext;
      aluCin       <= aluCinNext;
      bus.rspValid <= (nextState == RESP);
      case (state)
        IDLE: begin
          if (accept) begin
            opReg           <= bus.reqOp;
            setFlagsReg     <= bus.reqSetFlags;
            aHiReg          <= bus.reqAHi;
            bHiReg          <= bus.reqBHi;
            bus.rspErr      <= (nextState == RESP);
            bus.rspResult   <= '0;
            bus.rspResultHi <= '0;
          end
        end
        EXEC: begin
          bus.rspResult <= (opReg == OpCmp) ? '0 : aluBusOut;
          if (updFlags) begin
            statusZ <= flagZ;
            statusO <= flagO;
            statusC <= flagC;
            statusN <= flagN;
          end
        end
        LO: begin
          bus.rspResult <= aluBusOut;
          loZ           <= flagZ;
        end
        HI: begin
          // 64-bit zero needs both halves zero; N/O/C come from the high word
          bus.rspResultHi <= aluBusOut;
          if (updFlags) begin
            statusZ <= loZ & flagZ;
            statusO <= flagO;
            statusC <= flagC;
            statusN <= flagN;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table + scoreboard queue,
// with a behavioural 32-bit ALU/flag stub on the datapath side.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_sequencer_if bus();

  logic [31:0] aluA, aluB, aluBusOut;
  logic [1:0]  aluCtrl;
  logic        aluCin, aluCarryOut;
  logic        flagZ, flagO, flagC, flagN;
  logic        statusZ, statusO, statusC, statusN;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .bus(bus),
    .aluA(aluA), .aluB(aluB), .aluCtrl(aluCtrl), .aluCin(aluCin),
    .aluBusOut(aluBusOut), .aluCarryOut(aluCarryOut),
    .flagZ(flagZ), .flagO(flagO), .flagC(flagC), .flagN(flagN),
    .statusZ(statusZ), .statusO(statusO), .statusC(statusC), .statusN(statusN)
  );

  // Datapath stub: adder and flag unit
  logic [31:0] bEff;
  logic [32:0] sum33;
  always_comb begin
    bEff  = aluCtrl[0] ? ~aluB : aluB;
    sum33 = {1'b0, aluA} + {1'b0, bEff} + {32'd0, aluCin};
  end
  assign aluBusOut   = sum33[31:0];
  assign aluCarryOut = sum33[32];
  assign flagZ = (sum33[31:0] == 32'd0);
  assign flagN = sum33[31];
  assign flagC = sum33[32];
  assign flagO = (aluA[31] == bEff[31]) && (sum33[31] != aluA[31]);

  typedef struct {
    logic [2:0]  op;
    logic        sf;
    logic [31:0] a, b, aHi, bHi;
    logic [31:0] res, resHi;
    logic        err;
    logic [3:0]  st;   // {Z,O,C,N}
    int          lat;
  } vec_t;

  vec_t sbq[$];
  int   nApplied = 0;
  int   nMiss = 0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] status();
    return {statusZ, statusO, statusC, statusN};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkV(input logic [2:0] op, input logic sf, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] aHi, input logic [31:0] bHi,
                               input logic [31:0] res, input logic [31:0] resHi, input logic err,
                               input logic [3:0] st, input int lat);
    vec_t v;
    v.op = op; v.sf = sf; v.a = a; v.b = b; v.aHi = aHi; v.bHi = bHi;
    v.res = res; v.resHi = resHi; v.err = err; v.st = st; v.lat = lat;
    return v;
  endfunction

  // Reference for a full 64-bit add/subtract with flags (setFlags=1)
  function automatic vec_t mk64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] bE;
    logic [64:0] s;
    logic        o;
    bE = (op == 3'b101) ? ~b : b;
    s  = {1'b0, a} + {1'b0, bE} + ((op == 3'b101) ? 65'd1 : 65'd0);
    o  = (a[63] == bE[63]) && (s[63] != a[63]);
    return mkV(op, 1'b1, a[31:0], b[31:0], a[63:32], b[63:32], s[31:0], s[63:32], 1'b0,
               {(s[63:0] == 64'd0), o, s[64], s[63]}, 3);
  endfunction

  task automatic sendReq(input vec_t v, output int acceptEdge);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.reqReady && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("reqReady_idle", 64'(bus.reqReady), 64'd1);
    bus.reqValid = 1'b1; bus.reqOp = v.op; bus.reqSetFlags = v.sf;
    bus.reqA = v.a; bus.reqB = v.b; bus.reqAHi = v.aHi; bus.reqBHi = v.bHi;
    acceptEdge = cyc + 1;
    sbq.push_back(v);
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
  endtask

  task automatic checkOut(input vec_t e, input string tag);
    check({tag, "_rspValid"}, 64'(bus.rspValid), 64'd1);
    check({tag, "_result"}, 64'(bus.rspResult), 64'(e.res));
    check({tag, "_resultHi"}, 64'(bus.rspResultHi), 64'(e.resHi));
    check({tag, "_err"}, 64'(bus.rspErr), 64'(e.err));
    check({tag, "_status"}, 64'(status()), 64'(e.st));
    check({tag, "_reqReady"}, 64'(bus.reqReady), 64'd0);
    check({tag, "_aluIdle"}, {aluA, aluB}, 64'd0);
  endtask

  task automatic getRsp(input int acceptEdge, input int hold);
    vec_t e;
    int   k;
    k = 0;
    @(negedge clk);
    while (!bus.rspValid && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
      return;
    end
    e = sbq.pop_front();
    check("latency", 64'(cyc - acceptEdge + 1), 64'(e.lat));
    checkOut(e, "rsp");
    for (int i = 0; i < hold; i++) begin
      bus.reqValid = 1'b1; bus.reqOp = 3'b000; bus.reqA = 32'd1; bus.reqB = 32'd1;
      @(negedge clk);
      checkOut(e, "hold");
    end
    bus.reqValid = 1'b0;
    bus.rspReady = 1'b1;
    @(posedge clk);
    #1 bus.rspReady = 1'b0;
    @(negedge clk);
    check("post_rspValid", 64'(bus.rspValid), 64'd0);
    check("post_reqReady", 64'(bus.reqReady), 64'd1);
  endtask

  vec_t tbl[14];
  int   acc;
  bit   sawRsp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.reqValid = 1'b0; bus.reqOp = '0; bus.reqSetFlags = 1'b0;
    bus.reqA = '0; bus.reqB = '0; bus.reqAHi = '0; bus.reqBHi = '0; bus.rspReady = 1'b0;

    tbl[0]  = mkV(3'b000, 1, 32'd7, 32'd5, 0, 0, 32'd12, 0, 0, 4'b0000, 2);
    tbl[1]  = mkV(3'b001, 1, 32'd5, 32'd5, 0, 0, 32'd0, 0, 0, 4'b1010, 2);
    tbl[2]  = mkV(3'b011, 0, 32'd3, 32'd5, 0, 0, 32'd0, 0, 0, 4'b0001, 2);
    tbl[3]  = mkV(3'b000, 1, 32'hFFFFFFFF, 32'd1, 0, 0, 32'd0, 0, 0, 4'b1010, 2);
    tbl[4]  = mkV(3'b010, 0, 32'd0, 32'd0, 0, 0, 32'd1, 0, 0, 4'b1010, 2);
    tbl[5]  = mkV(3'b000, 1, 32'h7FFFFFFF, 32'd1, 0, 0, 32'h80000000, 0, 0, 4'b0101, 2);
    tbl[6]  = mkV(3'b100, 1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 0, 4'b0000, 3);
    tbl[7]  = mkV(3'b101, 1, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h12345678, 32'h12345678, 0, 0, 0, 4'b1010, 3);
    tbl[8]  = mkV(3'b111, 1, 32'd9, 32'd9, 32'd9, 32'd9, 0, 0, 1, 4'b1010, 1);
    tbl[9]  = mkV(3'b110, 1, 32'd1, 32'd2, 0, 0, 0, 0, 1, 4'b1010, 1);
    tbl[10] = mkV(3'b101, 1, 32'd0, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd0, 0, 4'b0010, 3);
    tbl[11] = mkV(3'b000, 0, 32'd1, 32'd1, 0, 0, 32'd2, 0, 0, 4'b0010, 2);
    tbl[12] = mkV(3'b010, 1, 32'hFFFFFFFF, 32'd0, 0, 0, 32'd0, 0, 0, 4'b1010, 2);
    tbl[13] = mkV(3'b011, 0, 32'd5, 32'd3, 0, 0, 32'd0, 0, 0, 4'b0010, 2);

    // reset state
    @(negedge clk);
    check("rst_reqReady", 64'(bus.reqReady), 64'd0);
    check("rst_rsp", {31'd0, bus.rspValid, bus.rspErr, bus.rspResult}, 64'd0);
    check("rst_resultHi", 64'(bus.rspResultHi), 64'd0);
    check("rst_status", 64'(status()), 64'd0);
    check("rst_alu", {aluA, aluB}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_release_reqReady", 64'(bus.reqReady), 64'd1);

    foreach (tbl[i]) begin
      sendReq(tbl[i], acc);
      getRsp(acc, 0);
    end

    // back-pressure, then an illegal op leaves status alone
    sendReq(mkV(3'b000, 1, 32'd9, 32'd6, 0, 0, 32'd15, 0, 0, 4'b0000, 2), acc);
    getRsp(acc, 5);
    sendReq(mkV(3'b111, 0, 32'd4, 32'd4, 0, 0, 0, 0, 1, 4'b0000, 1), acc);
    getRsp(acc, 0);

    for (int i = 0; i < 8; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = (i % 3 == 0) ? ra : {$urandom, $urandom};
      sendReq(mk64((i % 2 == 0) ? 3'b100 : 3'b101, ra, rb), acc);
      getRsp(acc, 0);
    end

    // reset during the high pass of ADD64 abandons it and clears status
    sendReq(mkV(3'b001, 1, 32'd5, 32'd5, 0, 0, 32'd0, 0, 0, 4'b1010, 2), acc);
    getRsp(acc, 0);
    sendReq(mkV(3'b100, 1, 32'hFFFFFFFF, 32'd1, 32'h11, 32'h22, 0, 0, 0, 0, 3), acc);
    void'(sbq.pop_back());
    @(negedge clk);
    check("lo_aluA", 64'(aluA), 64'hFFFFFFFF);
    @(negedge clk);
    check("hi_alu", {aluA, aluB}, {32'h11, 32'h22});
    check("hi_cin", 64'(aluCin), 64'd1);
    reset = 1'b1;
    #1 check("midrst_reqReady", 64'(bus.reqReady), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_rspValid", 64'(bus.rspValid), 64'd0);
    check("midrst_status", 64'(status()), 64'd0);
    check("midrst_reqReady", 64'(bus.reqReady), 64'd1);
    check("midrst_alu", {aluA, aluB}, 64'd0);
    sawRsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rspValid) sawRsp = 1'b1;
    end
    check("midrst_no_response", 64'(sawRsp), 64'd0);
    // ADC sees the cleared carry
    sendReq(mkV(3'b010, 1, 32'd1, 32'd1, 0, 0, 32'd2, 0, 0, 4'b0000, 2), acc);
    getRsp(acc, 0);

    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end
endmodule
